bldc_commutator: RTL and testbench
==================================

// Module: bldc_commutator
// PURPOSE
//  Six-step commutation controller for the 3-phase brushless driver: it sequences the
//  R/S/T half-bridges from filtered hall sensors, PWM-chops the high side and inserts
//  dead time on every step change. It runs an open-loop startup ramp and latches a fault
//  on stall or an invalid hall code. It sits between the user controls (sw1/sw2 -> enable/dir)
//  and the gate-driver pins HIN_*/LIN_*.
// PARAMETERS
//  PWM_PERIOD     1350     PWM counter period in clk cycles (20 kHz at 27 MHz)
//  DEAD_TIME      27       all-gates-off cycles inserted before every new step (1 us)
//  HALL_FILTER    4        consecutive identical synced samples needed to accept a hall code
//  OL_STEP_CYCLES 270000   open-loop dwell per step in clk cycles (10 ms)
//  OL_STEPS       12       open-loop steps issued before entering CLOSED
//  STALL_CYCLES   2700000  cycles without an accepted hall change before FAULT (100 ms)
// PORTS
//  clk          in   1   system clock, 27 MHz
//  rst          in   1   asynchronous reset, active-high
//  enable       in   1   level; 1 = run motor, 0 = stop and clear fault
//  dir          in   1   0 = forward (step +1), 1 = reverse (step -1)
//  duty         in   11  high-side on-time in clk cycles; values > PWM_PERIOD clip to PWM_PERIOD
//  HS           in   3   raw hall sensors, asynchronous
//  HIN_R/S/T    out  1   high-side gate enables
//  LIN_R/S/T    out  1   low-side gate enables
//  step         out  3   current commutation step 0..5
//  running      out  1   1 in CLOSED
//  fault        out  1   1 in FAULT
//  hall_period  out  24  clk cycles between the last two accepted hall changes, saturating
// BEHAVIOUR
//  Reset: all HIN/LIN 0, state IDLE, step 0, running 0, fault 0, hall_period 0, counters 0.
//  Hall path:
//   - 2-flop synchroniser, then a filter: a code becomes hall_f after HALL_FILTER equal samples.
//   - Sector map: 5->0, 4->1, 6->2, 2->3, 3->4, 1->5. Codes 000 and 111 are invalid.
//  Step table (PWM = pwm_on; ON = constant 1; all others 0):
//   - 0: HIN_R=PWM, LIN_S=ON    1: HIN_R=PWM, LIN_T=ON    2: HIN_S=PWM, LIN_T=ON
//   - 3: HIN_S=PWM, LIN_R=ON    4: HIN_T=PWM, LIN_R=ON    5: HIN_T=PWM, LIN_S=ON
//  PWM:
//   - Free-running counter 0..PWM_PERIOD-1; pwm_on = (cnt < duty_clipped).
//   - duty=0 gives a constant 0; duty>=PWM_PERIOD gives a constant 1.
//  Dead time: when the target step changes, all six gates go 0 for DEAD_TIME cycles, then
//   the new step's pattern is applied. `step` updates when the pattern is applied.
//   A further change during dead time restarts the dead-time count with the newest target.
//  Gate outputs are registered. HIN_x and LIN_x of the same phase are never 1 together.
//  States:
//   - IDLE: gates 0. enable=1 -> OPEN, with step 0 and counters cleared.
//   - OPEN: advance step by +/-1 mod 6 (dir) every OL_STEP_CYCLES. After OL_STEPS
//     advances -> CLOSED.
//   - CLOSED: target = sector(hall_f) when dir=0, (sector+3) mod 6 when dir=1.
//     Dir toggles take effect on the next evaluation and go through dead time.
//   - FAULT: gates 0, fault=1. Exits to IDLE only when enable=0.
//  FAULT entry (checked in CLOSED only):
//   - hall_f is invalid, or
//   - STALL_CYCLES elapse with no accepted hall change.
//   - Both conditions in the same cycle give a single FAULT.
//  enable=0 in any state -> IDLE next cycle, with gates 0 the same cycle IDLE is entered.
//  hall_period:
//   - An accepted hall change latches the inter-change count, then restarts it.
//   - The count saturates at 2^24-1. It is held in IDLE/FAULT.
//  Reset asserted mid-operation returns everything to reset values immediately (async).
// TESTING
//  1. Reset, enable=1, dir=0, duty=675, HS static 5 -> steps 0,1,..,11 (mod 6) at 10 ms
//     spacing, 27 dead cycles each, then running=1, step=0.
//  2. CLOSED, dir=0, HS sequence 5,4,6,2,3,1 -> step 0..5 in order. Each change shows exactly
//     27 all-zero gate cycles. Check HIN_R duty = 675/1350 in step 0.
//  3. CLOSED, HS held 6, dir toggled 0->1 -> step 2->5 after dead time. No HIN/LIN overlap on any phase.
//  4. CLOSED, HS=5 held for 2.7M cycles -> fault=1, gates 0. enable=0 -> IDLE, fault=0.
//     enable=1 -> OPEN restarts.
//  5. CLOSED, HS glitches to 7 for 3 cycles -> filter rejects it, no fault.
//     HS=7 for 4+ cycles -> FAULT.
//  6. duty=0 and duty=2047 in step 0 -> HIN_R constant 0 / constant 1, LIN_S=1.
//     rst pulsed mid-step -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step BLDC commutation with hall filter, PWM chop, dead time, open-loop start and fault latch
module bldc_commutator #(
  parameter int unsigned PWM_PERIOD     = 1350,
  parameter int unsigned DEAD_TIME      = 27,
  parameter int unsigned HALL_FILTER    = 4,
  parameter int unsigned OL_STEP_CYCLES = 270000,
  parameter int unsigned OL_STEPS       = 12,
  parameter int unsigned STALL_CYCLES   = 2700000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        dir,
  input  logic [10:0] duty,
  input  logic [2:0]  HS,
  output logic        HIN_R,
  output logic        HIN_S,
  output logic        HIN_T,
  output logic        LIN_R,
  output logic        LIN_S,
  output logic        LIN_T,
  output logic [2:0]  step,
  output logic        running,
  output logic        fault,
  output logic [23:0] hall_period
);
  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_CLOSED, S_FAULT} state_t;
  state_t state_q, state_d;
  logic [2:0] hs1_q, hs1_d, hs2_q, hs2_d, cand_q, cand_d, hall_f_q, hall_f_d;
  logic [2:0] tgt_q, tgt_d, step_q, step_d, sec;
  logic [31:0] flt_q, flt_d, pwm_q, pwm_d, ol_cnt_q, ol_cnt_d, ol_n_q, ol_n_d;
  logic [31:0] stall_q, stall_d, dt_q, dt_d, duty_c;
  logic [23:0] hp_cnt_q, hp_cnt_d, hp_q, hp_d, hp_inc;
  logic [5:0] g_q, g_d;
  logic hall_chg, bad_hall, pwm_on, run_d;
  function automatic logic [2:0] sector(input logic [2:0] h);
    return h == 3'd5 ? 3'd0 : h == 3'd4 ? 3'd1 : h == 3'd6 ? 3'd2 :
           h == 3'd2 ? 3'd3 : h == 3'd3 ? 3'd4 : 3'd5;
  endfunction
  function automatic logic [5:0] pattern(input logic [2:0] s, input logic p);
    logic [2:0] hin, lin;
    hin = s < 3'd2 ? 3'b100 : s < 3'd4 ? 3'b010 : 3'b001;
    lin = (s == 3'd0 || s == 3'd5) ? 3'b010 : (s == 3'd1 || s == 3'd2) ? 3'b001 : 3'b100;
    return {hin & {3{p}}, lin};
  endfunction
  always_comb begin
    hs1_d = HS;
    hs2_d = hs1_q;
    cand_d = hs2_q;
    flt_d = hs2_q != cand_q ? 32'd1 : flt_q == HALL_FILTER ? flt_q : flt_q + 32'd1;
    hall_f_d = flt_d == HALL_FILTER ? cand_d : hall_f_q;
    hall_chg = hall_f_d != hall_f_q;
    bad_hall = hall_f_q == 3'd0 || hall_f_q == 3'd7;
    sec = sector(hall_f_q);
    pwm_d = pwm_q == PWM_PERIOD - 1 ? 32'd0 : pwm_q + 32'd1;
    duty_c = 32'(duty) > PWM_PERIOD ? PWM_PERIOD : 32'(duty);
    pwm_on = pwm_q < duty_c;
    hp_inc = &hp_cnt_q ? hp_cnt_q : hp_cnt_q + 24'd1;
    state_d = state_q;
    tgt_d = tgt_q;
    ol_cnt_d = ol_cnt_q;
    ol_n_d = ol_n_q;
    stall_d = 32'd0;
    hp_cnt_d = hp_cnt_q;
    hp_d = hp_q;
    if (state_q == S_OPEN || state_q == S_CLOSED) begin
      hp_cnt_d = hall_chg ? 24'd0 : hp_inc;
      hp_d = hall_chg ? hp_inc : hp_q;
    end
    if (!enable)
      state_d = S_IDLE;
    else if (state_q == S_IDLE) begin
      state_d = S_OPEN;
      tgt_d = 3'd0;
      ol_cnt_d = 32'd0;
      ol_n_d = 32'd0;
      hp_cnt_d = 24'd0;
    end else if (state_q == S_OPEN) begin
      ol_cnt_d = ol_cnt_q == OL_STEP_CYCLES - 1 ? 32'd0 : ol_cnt_q + 32'd1;
      if (ol_cnt_q == OL_STEP_CYCLES - 1) begin
        tgt_d = dir ? (tgt_q == 3'd0 ? 3'd5 : tgt_q - 3'd1) : (tgt_q == 3'd5 ? 3'd0 : tgt_q + 3'd1);
        ol_n_d = ol_n_q + 32'd1;
        state_d = ol_n_q == OL_STEPS - 1 ? S_CLOSED : S_OPEN;
      end
    end else if (state_q == S_CLOSED) begin
      stall_d = hall_chg ? 32'd0 : stall_q + 32'd1;
      state_d = (bad_hall || (!hall_chg && stall_q >= STALL_CYCLES - 1)) ? S_FAULT : S_CLOSED;
      tgt_d = dir ? (sec >= 3'd3 ? sec - 3'd3 : sec + 3'd3) : sec;
    end
    run_d = state_d == S_OPEN || state_d == S_CLOSED;
    dt_d = !run_d ? 32'd0 : (state_q != S_IDLE && tgt_d != tgt_q) ? DEAD_TIME :
           dt_q == 32'd0 ? 32'd0 : dt_q - 32'd1;
    g_d = (run_d && dt_d == 32'd0) ? pattern(tgt_d, pwm_on) : 6'd0;
    step_d = (run_d && dt_d == 32'd0) ? tgt_d : step_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hs1_q <= 3'd0;
      hs2_q <= 3'd0;
      cand_q <= 3'd0;
      hall_f_q <= 3'd0;
      tgt_q <= 3'd0;
      step_q <= 3'd0;
      flt_q <= 32'd0;
      pwm_q <= 32'd0;
      ol_cnt_q <= 32'd0;
      ol_n_q <= 32'd0;
      stall_q <= 32'd0;
      dt_q <= 32'd0;
      hp_cnt_q <= 24'd0;
      hp_q <= 24'd0;
      g_q <= 6'd0;
    end else begin
      state_q <= state_d;
      hs1_q <= hs1_d;
      hs2_q <= hs2_d;
      cand_q <= cand_d;
      hall_f_q <= hall_f_d;
      tgt_q <= tgt_d;
      step_q <= step_d;
      flt_q <= flt_d;
      pwm_q <= pwm_d;
      ol_cnt_q <= ol_cnt_d;
      ol_n_q <= ol_n_d;
      stall_q <= stall_d;
      dt_q <= dt_d;
      hp_cnt_q <= hp_cnt_d;
      hp_q <= hp_d;
      g_q <= g_d;
    end
  end
  assign {HIN_R, HIN_S, HIN_T, LIN_R, LIN_S, LIN_T} = g_q;
  assign step = step_q;
  assign running = state_q == S_CLOSED;
  assign fault = state_q == S_FAULT;
  assign hall_period = hp_q;
endmodule

// File: tb/tb_bldc_commutator.sv
// tb_bldc_commutator: directed self-checking bench for bldc_commutator with shortened timing parameters
module tb_bldc_commutator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic dir = 1'b0;
  logic [10:0] duty = 11'd675;
  logic [2:0] HS = 3'd5;
  logic HIN_R, HIN_S, HIN_T, LIN_R, LIN_S, LIN_T, running, fault;
  logic [2:0] step;
  logic [23:0] hall_period;
  logic [5:0] g;
  int tests = 0;
  int fails = 0;
  int overlap = 0;
  bldc_commutator #(
    .PWM_PERIOD(1350), .DEAD_TIME(27), .HALL_FILTER(4),
    .OL_STEP_CYCLES(400), .OL_STEPS(12), .STALL_CYCLES(3000)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .dir(dir), .duty(duty), .HS(HS),
    .HIN_R(HIN_R), .HIN_S(HIN_S), .HIN_T(HIN_T),
    .LIN_R(LIN_R), .LIN_S(LIN_S), .LIN_T(LIN_T),
    .step(step), .running(running), .fault(fault), .hall_period(hall_period)
  );
  assign g = {HIN_R, HIN_S, HIN_T, LIN_R, LIN_S, LIN_T};
  always #5 clk = ~clk;
  always @(negedge clk)
    if ((HIN_R && LIN_R) || (HIN_S && LIN_S) || (HIN_T && LIN_T)) overlap++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_win(input int n, output int zeros, output int hin_r, output int lin_s);
    zeros = 0;
    hin_r = 0;
    lin_s = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (g == 6'd0) zeros++;
      if (HIN_R) hin_r++;
      if (LIN_S) lin_s++;
    end
  endtask
  initial begin
    int z, hr, ls, cnt;
    logic [2:0] prev;
    logic [2:0] hs_seq [6];
    hs_seq = '{3'd4, 3'd6, 3'd2, 3'd3, 3'd1, 3'd5};
    repeat (3) tick();
    chk("reset_gates", 32'(g), 0);
    chk("reset_step", 32'(step), 0);
    chk("reset_running", 32'(running), 0);
    chk("reset_fault", 32'(fault), 0);
    chk("reset_hall_period", 32'(hall_period), 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      prev = step;
      cnt = 0;
      z = 0;
      while (step == prev && cnt < 2000) begin
        tick();
        cnt++;
        if (g == 6'd0) z++;
      end
      chk($sformatf("ol_step%0d", i), 32'(step), 32'((i + 1) % 6));
      chk($sformatf("ol_dead%0d", i), z, 27);
      chk($sformatf("ol_gap%0d", i), cnt, i == 0 ? 428 : 400);
      chk($sformatf("ol_running%0d", i), 32'(running), 32'(i == 11));
    end
    chk("closed_running", 32'(running), 1);
    chk("closed_step", 32'(step), 0);
    for (int i = 0; i < 6; i++) begin
      HS = hs_seq[i];
      run_win(60, z, hr, ls);
      chk($sformatf("cl_step_hs%0d", hs_seq[i]), 32'(step), 32'((i + 1) % 6));
      chk($sformatf("cl_dead_hs%0d", hs_seq[i]), z, 27);
      if (i > 0) chk($sformatf("cl_period_hs%0d", hs_seq[i]), 32'(hall_period), 60);
    end
    run_win(1350, z, hr, ls);
    chk("duty675_hin_r", hr, 675);
    chk("duty675_lin_s", ls, 1350);
    duty = 11'd0;
    run_win(100, z, hr, ls);
    chk("duty0_hin_r", hr, 0);
    chk("duty0_lin_s", ls, 100);
    duty = 11'd2047;
    run_win(100, z, hr, ls);
    chk("duty2047_hin_r", hr, 100);
    chk("duty2047_lin_s", ls, 100);
    duty = 11'd675;
    HS = 3'd6;
    run_win(60, z, hr, ls);
    chk("dir0_step", 32'(step), 2);
    dir = 1'b1;
    run_win(60, z, hr, ls);
    chk("dir1_step", 32'(step), 5);
    chk("dir1_dead", z, 27);
    chk("no_overlap", overlap, 0);
    HS = 3'd7;
    repeat (3) tick();
    HS = 3'd6;
    run_win(30, z, hr, ls);
    chk("glitch_fault", 32'(fault), 0);
    chk("glitch_step", 32'(step), 5);
    chk("glitch_dead", z, 0);
    HS = 3'd7;
    run_win(20, z, hr, ls);
    chk("invalid_fault", 32'(fault), 1);
    chk("invalid_running", 32'(running), 0);
    chk("invalid_gates", 32'(g), 0);
    enable = 1'b0;
    HS = 3'd5;
    dir = 1'b0;
    repeat (2) tick();
    chk("disable_fault", 32'(fault), 0);
    enable = 1'b1;
    run_win(3, z, hr, ls);
    chk("reopen_step", 32'(step), 0);
    chk("reopen_lin_s", 32'(LIN_S), 1);
    chk("reopen_running", 32'(running), 0);
    cnt = 0;
    while (!running && cnt < 6000) begin
      tick();
      cnt++;
    end
    chk("reclosed_running", 32'(running), 1);
    cnt = 0;
    while (!fault && cnt < 4000) begin
      tick();
      cnt++;
    end
    chk("stall_fault", 32'(fault), 1);
    chk("stall_cycles", cnt, 3000);
    chk("stall_gates", 32'(g), 0);
    enable = 1'b0;
    repeat (2) tick();
    chk("stall_clear", 32'(fault), 0);
    enable = 1'b1;
    run_win(450, z, hr, ls);
    chk("pre_rst_step", 32'(step), 1);
    rst = 1'b1;
    #2;
    chk("async_rst_gates", 32'(g), 0);
    chk("async_rst_step", 32'(step), 0);
    chk("async_rst_running", 32'(running), 0);
    chk("async_rst_hall_period", 32'(hall_period), 0);
    tick();
    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
